// File: rtl/inst_fetch_port.sv
// inst_fetch_port: instruction-side memory port with a one-word line buffer.
// Hits are served from the buffer in one cycle. A miss goes through an
// address phase and a data phase on the memory side. MEM_WAIT freezes the
// core while the miss is outstanding.
module inst_fetch_port #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INST_RDEN,
    input  logic [ADDR_W-1:0] INST_RIADDR,
    output logic [ADDR_W-1:0] INST_ROADDR,
    output logic              INST_RVALID,
    output logic [31:0]       INST_RDATA,
    output logic              MEM_WAIT,
    input  logic              INVALIDATE,
    output logic              M_ARVALID,
    output logic [ADDR_W-1:0] M_ARADDR,
    input  logic              M_ARREADY,
    input  logic              M_RVALID,
    input  logic [31:0]       M_RDATA,
    output logic              M_RREADY,
    output logic [31:0]       HIT_CNT,
    output logic [31:0]       MISS_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   lat_addr_reg;
    logic                buf_valid_reg;
    logic [ADDR_W-1:2]   buf_addr_reg;
    logic [31:0]         buf_data_reg;
    logic                out_valid_reg;
    logic [ADDR_W-1:0]   out_addr_reg;
    logic [31:0]         out_data_reg;
    logic [31:0]         hit_cnt_reg;
    logic [31:0]         miss_cnt_reg;

    logic hit;
    logic miss;
    logic refill;
    logic mem_wait;

    // Next-state decode, hit/miss classification and stall generation
    always_comb begin
        state_next = state_reg;
        hit        = 1'b0;
        miss       = 1'b0;
        refill     = 1'b0;
        mem_wait   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (RST && INST_RDEN) begin
                    // A concurrent invalidate turns a would-be hit into a miss
                    if (buf_valid_reg && !INVALIDATE &&
                        (INST_RIADDR[ADDR_W-1:2] == buf_addr_reg)) begin
                        hit = 1'b1;
                    end else begin
                        miss       = 1'b1;
                        mem_wait   = 1'b1;
                        state_next = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                mem_wait = 1'b1;
                if (M_ARREADY) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (M_RVALID) begin
                    refill     = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The core is never stalled while reset is held
    assign MEM_WAIT  = RST & mem_wait;
    assign M_ARVALID = (state_reg == ST_ADDR);
    assign M_ARADDR  = {lat_addr_reg[ADDR_W-1:2], 2'b00};
    assign M_RREADY  = (state_reg == ST_DATA);

    assign INST_RVALID = out_valid_reg;
    assign INST_ROADDR = out_addr_reg;
    assign INST_RDATA  = out_data_reg;
    assign HIT_CNT     = hit_cnt_reg;
    assign MISS_CNT    = miss_cnt_reg;

    // State register and miss address latch
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg    <= ST_IDLE;
            lat_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (miss) begin
                lat_addr_reg <= INST_RIADDR;
            end
        end
    end

    // Line buffer: refilled on miss completion, invalidate has priority
    always_ff @(posedge CLK) begin
        if (!RST) begin
            buf_valid_reg <= 1'b0;
            buf_addr_reg  <= '0;
            buf_data_reg  <= '0;
        end else begin
            if (INVALIDATE) begin
                buf_valid_reg <= 1'b0;
            end else if (refill) begin
                buf_valid_reg <= 1'b1;
            end
            if (refill) begin
                buf_addr_reg <= lat_addr_reg[ADDR_W-1:2];
                buf_data_reg <= M_RDATA;
            end
        end
    end

    // Output register: frozen on stalled edges so each word is consumed once
    always_ff @(posedge CLK) begin
        if (!RST) begin
            out_valid_reg <= 1'b0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
        end else if (!mem_wait) begin
            if (hit) begin
                out_valid_reg <= 1'b1;
                out_addr_reg  <= INST_RIADDR;
                out_data_reg  <= buf_data_reg;
            end else if (refill) begin
                out_valid_reg <= 1'b1;
                out_addr_reg  <= lat_addr_reg;
                out_data_reg  <= M_RDATA;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // Saturating hit and miss counters
    always_ff @(posedge CLK) begin
        if (!RST) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (hit && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
            if (miss && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_port.sv
// Testbench for inst_fetch_port: table of fetch transactions against a
// configurable-latency memory responder, plus reset sequences.
module tb_inst_fetch_port;

    logic        clk;
    logic        rst;
    logic        inst_rden;
    logic [31:0] inst_riaddr;
    logic [31:0] inst_roaddr;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        mem_wait;
    logic        invalidate;
    logic        m_arvalid;
    logic [31:0] m_araddr;
    logic        m_arready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        m_rready;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    // responder configuration
    int          cfg_ar_wait = 0;
    int          cfg_r_wait  = 0;
    logic [31:0] cfg_data    = 32'h0;
    int          ar_cnt = 0;
    int          r_cnt  = 0;

    // last delivered instruction, for hold checks during stalls
    logic        last_valid = 1'b0;
    logic [31:0] last_addr  = 32'h0;
    logic [31:0] last_data  = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          ar_wait;
        int          r_wait;
        logic [31:0] mem_data;
        int          inval;      // 0 none, 1 in the M_RVALID cycle, 2 in the request cycle
        int          exp_stalls;
        logic [31:0] exp_data;
        logic [31:0] exp_hit;
        logic [31:0] exp_miss;
    } vec_t;

    vec_t vecs[11];

    inst_fetch_port #(.ADDR_W(32)) dut (
        .CLK        (clk),
        .RST        (rst),
        .INST_RDEN  (inst_rden),
        .INST_RIADDR(inst_riaddr),
        .INST_ROADDR(inst_roaddr),
        .INST_RVALID(inst_rvalid),
        .INST_RDATA (inst_rdata),
        .MEM_WAIT   (mem_wait),
        .INVALIDATE (invalidate),
        .M_ARVALID  (m_arvalid),
        .M_ARADDR   (m_araddr),
        .M_ARREADY  (m_arready),
        .M_RVALID   (m_rvalid),
        .M_RDATA    (m_rdata),
        .M_RREADY   (m_rready),
        .HIT_CNT    (hit_cnt),
        .MISS_CNT   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ARREADY after cfg_ar_wait low cycles of ARVALID,
    // RVALID after cfg_r_wait low cycles of RREADY
    always @(negedge clk) begin
        if (m_arvalid) begin
            m_arready = (ar_cnt >= cfg_ar_wait);
            ar_cnt++;
        end else begin
            m_arready = 1'b0;
            ar_cnt = 0;
        end
        if (m_rready) begin
            m_rvalid = (r_cnt >= cfg_r_wait);
            r_cnt++;
        end else begin
            m_rvalid = 1'b0;
            r_cnt = 0;
        end
        m_rdata = cfg_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic fetch(input vec_t v, input string tag);
        int stalls;
        bit saw_ar;
        bit timeout;
        cfg_ar_wait = v.ar_wait;
        cfg_r_wait  = v.r_wait;
        cfg_data    = v.mem_data;
        @(negedge clk);
        inst_rden   = 1'b1;
        inst_riaddr = v.addr;
        invalidate  = (v.inval == 2);
        stalls  = 0;
        saw_ar  = 1'b0;
        timeout = 1'b0;
        #1;
        while (mem_wait) begin
            stalls++;
            if (m_arvalid && !saw_ar) begin
                saw_ar = 1'b1;
                chk({tag, " araddr"}, m_araddr, v.addr & 32'hFFFF_FFFC);
            end
            if (m_rready && m_arvalid) chk({tag, " one_outstanding"}, 32'd1, 32'd0);
            if (stalls > 60) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            invalidate = 1'b0;
            chk({tag, " hold_valid"}, {31'd0, inst_rvalid}, {31'd0, last_valid});
            chk({tag, " hold_addr"}, inst_roaddr, last_addr);
            chk({tag, " hold_data"}, inst_rdata, last_data);
            @(negedge clk);
            #1;
        end
        chk({tag, " timeout"}, {31'd0, timeout}, 32'd0);
        chk({tag, " stalls"}, stalls, v.exp_stalls);
        chk({tag, " ar_issued"}, {31'd0, saw_ar}, {31'd0, (v.exp_stalls != 0)});
        if (v.inval == 1) invalidate = 1'b1;
        @(posedge clk);
        #1;
        invalidate = 1'b0;
        chk({tag, " rvalid"}, {31'd0, inst_rvalid}, 32'd1);
        chk({tag, " roaddr"}, inst_roaddr, v.addr);
        chk({tag, " rdata"}, inst_rdata, v.exp_data);
        chk({tag, " hit_cnt"}, hit_cnt, v.exp_hit);
        chk({tag, " miss_cnt"}, miss_cnt, v.exp_miss);
        $display("fetch %s addr=0x%08h stalls=%0d data=0x%08h hit=%0d miss=%0d",
                 tag, v.addr, stalls, inst_rdata, hit_cnt, miss_cnt);
        last_valid = 1'b1;
        last_addr  = v.addr;
        last_data  = v.exp_data;
    endtask

    initial begin
        vec_t v;
        //           addr          aw rw data          inv st data          hit  miss
        vecs[0]  = '{32'h0000_0100, 0, 0, 32'h0000_0093, 0, 2, 32'h0000_0093, 32'd0, 32'd1};
        vecs[1]  = '{32'h0000_0102, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_0093, 32'd1, 32'd1};
        vecs[2]  = '{32'h0000_0200, 3, 3, 32'h0000_0013, 0, 8, 32'h0000_0013, 32'd1, 32'd2};
        vecs[3]  = '{32'h0000_0200, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_0013, 32'd2, 32'd2};
        vecs[4]  = '{32'h0000_0204, 1, 0, 32'h0000_00AB, 1, 3, 32'h0000_00AB, 32'd2, 32'd3};
        vecs[5]  = '{32'h0000_0204, 0, 1, 32'h0000_00CD, 0, 3, 32'h0000_00CD, 32'd2, 32'd4};
        vecs[6]  = '{32'h0000_0206, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_00CD, 32'd3, 32'd4};
        vecs[7]  = '{32'h0000_0303, 0, 0, 32'h0000_0055, 0, 2, 32'h0000_0055, 32'd3, 32'd5};
        vecs[8]  = '{32'h0000_0300, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_0055, 32'd4, 32'd5};
        vecs[9]  = '{32'h0000_0300, 0, 0, 32'h0000_0066, 2, 2, 32'h0000_0066, 32'd4, 32'd6};
        vecs[10] = '{32'h0000_0300, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_0066, 32'd5, 32'd6};

        rst = 1'b0;
        inst_rden = 1'b1;
        inst_riaddr = 32'h0000_0100;
        invalidate = 1'b0;
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = 32'h0;

        // reset held for two cycles with a pending fetch
        repeat (2) @(posedge clk);
        #1;
        chk("rst rvalid", {31'd0, inst_rvalid}, 32'd0);
        chk("rst roaddr", inst_roaddr, 32'd0);
        chk("rst rdata", inst_rdata, 32'd0);
        chk("rst arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("rst rready", {31'd0, m_rready}, 32'd0);
        chk("rst mem_wait", {31'd0, mem_wait}, 32'd0);
        chk("rst hit_cnt", hit_cnt, 32'd0);
        chk("rst miss_cnt", miss_cnt, 32'd0);
        $display("reset: rvalid=%0d arvalid=%0d hit=%0d miss=%0d", inst_rvalid, m_arvalid, hit_cnt, miss_cnt);
        @(negedge clk);
        rst = 1'b1;
        inst_rden = 1'b0;

        for (int i = 0; i < 11; i++) begin
            fetch(vecs[i], $sformatf("v%0d", i));
        end

        // idle cycle drops INST_RVALID
        @(negedge clk);
        inst_rden = 1'b0;
        @(posedge clk);
        #1;
        chk("idle rvalid", {31'd0, inst_rvalid}, 32'd0);
        chk("idle hit_cnt", hit_cnt, 32'd5);
        $display("idle: rvalid=%0d", inst_rvalid);
        last_valid = 1'b0;

        // reset while the miss is waiting in the data phase
        cfg_ar_wait = 0;
        cfg_r_wait  = 10;
        cfg_data    = 32'h0000_0099;
        @(negedge clk);
        inst_rden   = 1'b1;
        inst_riaddr = 32'h0000_0400;
        for (int i = 0; i < 20 && !m_rready; i++) @(negedge clk);
        chk("midrst in_data", {31'd0, m_rready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst rready", {31'd0, m_rready}, 32'd0);
        chk("midrst arvalid", {31'd0, m_arvalid}, 32'd0);
        chk("midrst rvalid", {31'd0, inst_rvalid}, 32'd0);
        chk("midrst mem_wait", {31'd0, mem_wait}, 32'd0);
        chk("midrst miss_cnt", miss_cnt, 32'd0);
        chk("midrst hit_cnt", hit_cnt, 32'd0);
        $display("midrst: rready=%0d arvalid=%0d miss=%0d", m_rready, m_arvalid, miss_cnt);
        @(negedge clk);
        rst = 1'b1;
        inst_rden = 1'b0;
        last_valid = 1'b0;
        last_addr  = 32'h0;
        last_data  = 32'h0;
        v = '{32'h0000_0400, 0, 0, 32'h0000_0077, 0, 2, 32'h0000_0077, 32'd0, 32'd1};
        fetch(v, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
